// File: rtl/rbb_pkg.sv
// rbb_pkg: shared types and helpers for the multi-bank result batch buffer.
// Holds the drain FSM states, bank-width function and default index types.
package rbb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } rbb_state_e;

    function automatic int rbb_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    localparam int RBB_ADDR_WIDTH_DEF = 8;
    localparam int RBB_DATA_WIDTH_DEF = 512;
    localparam int NUM_BANKS_DEF      = 2;

    typedef logic [RBB_ADDR_WIDTH_DEF-1:0]           rbb_line_t;
    typedef logic [rbb_clog2(NUM_BANKS_DEF)-1:0]     rbb_bank_t;
    typedef logic [RBB_DATA_WIDTH_DEF-1:0]           rbb_data_t;

endpackage

// File: rtl/rbb_mb_if.sv
// rbb_mb_if: PE-array write/commit port and host drain handshake.
// master = PE array + host side, slave = buffer side.
interface rbb_mb_if
    import rbb_pkg::*;
#(
    parameter int RBB_ADDR_WIDTH = 8,
    parameter int RBB_DATA_WIDTH = 512,
    parameter int NUM_BANKS      = 2
);
    localparam int BANK_W = rbb_clog2(NUM_BANKS);

    logic                      WrEn;
    logic [RBB_ADDR_WIDTH-1:0] WrAddr;
    logic [RBB_DATA_WIDTH-1:0] WrDin;
    logic                      task_done;
    logic [RBB_ADDR_WIDTH-1:0] TaskLen;
    logic                      ReqValid;
    logic [RBB_ADDR_WIDTH-1:0] ReqLineIdx;
    logic [BANK_W-1:0]         ReqBank;
    logic [RBB_DATA_WIDTH-1:0] RdDout;
    logic                      ReqAck;
    logic                      Full;
    logic                      Empty;
    logic [BANK_W:0]           BankCount;
    logic                      ErrOvf;

    modport master (
        output WrEn, WrAddr, WrDin, task_done, TaskLen, ReqAck,
        input  ReqValid, ReqLineIdx, ReqBank, RdDout,
        input  Full, Empty, BankCount, ErrOvf
    );

    modport slave (
        input  WrEn, WrAddr, WrDin, task_done, TaskLen, ReqAck,
        output ReqValid, ReqLineIdx, ReqBank, RdDout,
        output Full, Empty, BankCount, ErrOvf
    );

endinterface

// File: rtl/nlb_gram_sdp.sv
// nlb_gram_sdp: simple dual-port RAM, one write port, one registered read port.
// The read register only updates on i_re so its output can be held as a stable bus.
module nlb_gram_sdp #(
    parameter int BUS_SIZE_ADDR = 9,
    parameter int BUS_SIZE_DATA = 512
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [BUS_SIZE_ADDR-1:0] i_waddr,
    input  logic [BUS_SIZE_DATA-1:0] i_din,
    input  logic                     i_re,
    input  logic [BUS_SIZE_ADDR-1:0] i_raddr,
    output logic [BUS_SIZE_DATA-1:0] o_dout
);
    logic [BUS_SIZE_DATA-1:0] r_mem [2**BUS_SIZE_ADDR];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n)  o_dout <= '0;
        else if (i_re) o_dout <= r_mem[i_raddr];
    end

endmodule

// File: rtl/rbb_mb.sv
// rbb_mb: multi-bank result batch buffer, PE array fill -> host line drain.
// Define RBB_PARTIAL_BATCH_EN to honour TaskLen (per-commit batch length).
module rbb_mb
    import rbb_pkg::*;
#(
    parameter int RBB_ADDR_WIDTH = 8,
    parameter int RBB_DATA_WIDTH = 512,
    parameter int NUM_BANKS      = 2
) (
    input logic     clk,
    input logic     reset_n,
    rbb_mb_if.slave bus
);
    localparam int BANK_W = rbb_clog2(NUM_BANKS);
    localparam int RAM_AW = RBB_ADDR_WIDTH + BANK_W;
    localparam logic [BANK_W:0] CNT_FULL = (BANK_W+1)'(NUM_BANKS);

    rbb_state_e                r_state;
    logic [RBB_ADDR_WIDTH-1:0] r_line;
    logic [BANK_W-1:0]         r_wr_bank;
    logic [BANK_W-1:0]         r_rd_bank;
    logic [BANK_W:0]           r_cnt;
    logic                      r_req_valid;
    logic                      r_err_ovf;

    logic                      w_full;
    logic                      w_wr;
    logic                      w_commit;
    logic                      w_ovf;
    logic                      w_last_hit;
    logic                      w_release;
    logic [BANK_W:0]           w_cnt_nxt;
    logic [RBB_ADDR_WIDTH-1:0] w_last;
    logic [RBB_DATA_WIDTH-1:0] w_ram_q;

`ifdef RBB_PARTIAL_BATCH_EN
    logic [RBB_ADDR_WIDTH-1:0] r_len [NUM_BANKS];

    always_ff @(posedge clk) begin
        if (w_commit) r_len[r_wr_bank] <= bus.TaskLen;
    end

    assign w_last = r_len[r_rd_bank];
`else
    logic w_unused_tasklen;

    assign w_unused_tasklen = ^bus.TaskLen;
    assign w_last           = '1;
`endif

    assign w_full     = (r_cnt == CNT_FULL);
    assign w_wr       = bus.WrEn && !w_full;
    assign w_commit   = bus.task_done && !w_full;
    assign w_ovf      = (bus.WrEn || bus.task_done) && w_full;
    assign w_last_hit = (r_line == w_last);
    assign w_release  = r_req_valid && bus.ReqAck && w_last_hit;
    assign w_cnt_nxt  = r_cnt + (BANK_W+1)'(w_commit)
                              - (BANK_W+1)'(w_release);

    nlb_gram_sdp #(
        .BUS_SIZE_ADDR (RAM_AW),
        .BUS_SIZE_DATA (RBB_DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_rst_n (reset_n),
        .i_we    (w_wr),
        .i_waddr ({r_wr_bank, bus.WrAddr}),
        .i_din   (bus.WrDin),
        .i_re    (r_state == ST_LOAD),
        .i_raddr ({r_rd_bank, r_line}),
        .o_dout  (w_ram_q)
    );

    // A commit in the idle cycle starts LOAD at once so ReqValid lands at T+2.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_line      <= '0;
            r_wr_bank   <= '0;
            r_rd_bank   <= '0;
            r_cnt       <= '0;
            r_req_valid <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_ovf)     r_err_ovf <= 1'b1;
            if (w_commit)  r_wr_bank <= r_wr_bank + BANK_W'(1);
            if (w_release) r_rd_bank <= r_rd_bank + BANK_W'(1);
            unique case (r_state)
                ST_IDLE: begin
                    if (r_cnt != '0 || w_commit) begin
                        r_line  <= '0;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_req_valid <= 1'b1;
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (bus.ReqAck) begin
                        r_req_valid <= 1'b0;
                        if (w_last_hit) begin
                            r_line  <= '0;
                            r_state <= (w_cnt_nxt != '0) ? ST_LOAD
                                                         : ST_IDLE;
                        end else begin
                            r_line  <= r_line + RBB_ADDR_WIDTH'(1);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ReqValid   = r_req_valid;
    assign bus.ReqLineIdx = r_line;
    assign bus.ReqBank    = r_rd_bank;
    assign bus.RdDout     = w_ram_q;
    assign bus.Full       = w_full;
    assign bus.Empty      = (r_cnt == '0);
    assign bus.BankCount  = r_cnt;
    assign bus.ErrOvf     = r_err_ovf;

endmodule
